// File: rtl/gpio_cfg_serializer.sv
// Serializer feeding per-pad GPIO configuration words into the pad control chain.
// Optional chain clear output serial_resetn enabled by defining GPIO_CFG_RESETN_EN.
module gpio_cfg_serializer #(
    parameter int NUM_IO   = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2,
    localparam int AW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_data,
`ifdef GPIO_CFG_RESETN_EN
    output logic                serial_resetn,
`endif
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load
);

    localparam int DW = $clog2(2 * CLK_DIV + 1);
    localparam int BW = $clog2(CFG_BITS + 1);

    localparam logic [AW-1:0] LAST_PAD = AW'(NUM_IO - 1);
    localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] FULL_END = DW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_END  = BW'(CFG_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef GPIO_CFG_RESETN_EN
        CLEAR,
`endif
        FETCH,
        LATCH,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } state_t;

    state_t              state;
    logic [CFG_BITS-1:0] shreg;
    logic [BW-1:0]       bit_cnt;
    logic [DW-1:0]       div_cnt;

    // Transfer sequencer: fetch each pad word, shift it out MSB-first, then strobe load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_addr     <= LAST_PAD;
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
`ifdef GPIO_CFG_RESETN_EN
            serial_resetn <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
`ifdef GPIO_CFG_RESETN_EN
                    serial_resetn <= 1'b1;
`endif
                    if (start) begin
                        cfg_addr <= LAST_PAD;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
`ifdef GPIO_CFG_RESETN_EN
                        serial_resetn <= 1'b0;
                        state         <= CLEAR;
`else
                        state    <= FETCH;
`endif
                    end
                end
`ifdef GPIO_CFG_RESETN_EN
                CLEAR: begin
                    if (div_cnt == FULL_END) begin
                        div_cnt       <= '0;
                        serial_resetn <= 1'b1;
                        state         <= FETCH;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
`endif
                FETCH: begin
                    state <= LATCH;
                end
                LATCH: begin
                    shreg        <= cfg_data;
                    bit_cnt      <= '0;
                    div_cnt      <= '0;
                    serial_clock <= 1'b0;
                    serial_data  <= cfg_data[CFG_BITS-1];
                    state        <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (div_cnt == HALF_END) begin
                        div_cnt      <= '0;
                        serial_clock <= 1'b1;
                        state        <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt == HALF_END) begin
                        div_cnt      <= '0;
                        serial_clock <= 1'b0;
                        shreg        <= shreg << 1;
                        bit_cnt      <= bit_cnt + BW'(1);
                        if (bit_cnt == BIT_END) begin
                            if (cfg_addr == '0) begin
                                serial_data <= 1'b0;
                                serial_load <= 1'b1;
                                state       <= LOAD;
                            end else begin
                                cfg_addr <= cfg_addr - AW'(1);
                                state    <= FETCH;
                            end
                        end else begin
                            serial_data <= shreg[CFG_BITS-2];
                            state       <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                LOAD: begin
                    if (div_cnt == HALF_END) begin
                        serial_load <= 1'b0;
                    end
                    if (div_cnt == FULL_END) begin
                        div_cnt <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                DONE: begin
                    cfg_addr <= LAST_PAD;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
